// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg -- shared definitions for the 5-stage core control path.
//   * RV32 base opcode constants used by the main decoder.
//   * ALUOp encodings produced by the decoder.
//   * Forwarding-select encodings consumed by the EX operand muxes.
//   * ctrl_bundle_t: the decoder control bundle carried down the pipe.
//   * fwd_sel_f: priority encoder for the forwarding select.
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int unsigned REG_AW_C  = 5;
  localparam int unsigned ALUOP_W_C = 2;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [ALUOP_W_C-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W_C-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W_C-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                 branch;
    logic                 memread;
    logic                 memtoreg;
    logic                 memwrite;
    logic                 alusrc;
    logic                 regwrite;
    logic [ALUOP_W_C-1:0] aluop;
  } ctrl_bundle_t;

  // The younger producer (EX/MEM) wins over the older one (MEM/WB).
  function automatic logic [1:0] fwd_sel_f(input logic hit_mem, input logic hit_wb);
    logic [1:0] sel;
    if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/rv_fwd_unit.sv
// ---------------------------------------------------------------------------
// rv_fwd_unit -- combinational forwarding compare for one ALU operand.
// Ports:
//   rs            in   source register index of the instruction in EX
//   mem_regwrite  in   EX/MEM writes a register
//   mem_rd        in   EX/MEM destination index
//   wb_regwrite   in   MEM/WB writes a register
//   wb_rd         in   MEM/WB destination index
//   fwd_sel       out  FWD_MEM / FWD_WB / FWD_RF
// x0 is hard-wired zero, so a destination of 0 never produces a forward.
// ---------------------------------------------------------------------------
module rv_fwd_unit #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_sel
);
  import rv_pkg::*;

  logic hit_mem_s;
  logic hit_wb_s;

  // Match the operand against both older in-flight producers.
  always_comb begin
    hit_mem_s = mem_regwrite && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == rs);
    hit_wb_s  = wb_regwrite  && (wb_rd  != {REG_AW{1'b0}}) && (wb_rd  == rs);
    fwd_sel   = fwd_sel_f(hit_mem_s, hit_wb_s);
  end

endmodule

// File: rtl/rv_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pipe -- control half of the ID/EX, EX/MEM and MEM/WB pipeline
// registers, plus hazard detection, branch squash and forwarding selects.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_*                  decoder bundle and register fields of the ID instr
//   ex_zero               ALU zero flag of the instruction in EX
//   ex_*                  ID/EX control and indices
//   mem_*                 EX/MEM control subset and destination
//   wb_*                  MEM/WB control subset and destination
//   pc_write, ifid_write  0 = hold PC / IF-ID (load-use stall)
//   ifid_flush            1 = clear IF/ID next edge (taken branch)
//   pcsrc                 1 = select branch target
//   fwd_a, fwd_b          ALU operand forwarding selects
//
// Build option RV_CTRL_FORWARD_EN:
//   defined   -> forwarding active, only load-use stalls.
//   undefined -> fwd_a/fwd_b tied to FWD_RF and any RAW against EX or MEM
//                stalls the front end instead.
// ---------------------------------------------------------------------------
module rv_ctrl_pipe #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_branch,
  input  logic               id_memread,
  input  logic               id_memtoreg,
  input  logic               id_memwrite,
  input  logic               id_alusrc,
  input  logic               id_regwrite,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               ex_zero,
  output logic               ex_branch,
  output logic               ex_memread,
  output logic               ex_memtoreg,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               mem_memread,
  output logic               mem_memwrite,
  output logic               mem_memtoreg,
  output logic               mem_regwrite,
  output logic [REG_AW-1:0]  mem_rd,
  output logic               wb_memtoreg,
  output logic               wb_regwrite,
  output logic [REG_AW-1:0]  wb_rd,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               ifid_flush,
  output logic               pcsrc,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b
);
  import rv_pkg::*;

  // ID/EX
  ctrl_bundle_t      idex_q, idex_d;
  logic [REG_AW-1:0] idex_rs1_q, idex_rs1_d;
  logic [REG_AW-1:0] idex_rs2_q, idex_rs2_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  // EX/MEM
  logic              exmem_memread_q, exmem_memread_d;
  logic              exmem_memwrite_q, exmem_memwrite_d;
  logic              exmem_memtoreg_q, exmem_memtoreg_d;
  logic              exmem_regwrite_q, exmem_regwrite_d;
  logic [REG_AW-1:0] exmem_rd_q, exmem_rd_d;
  // MEM/WB
  logic              memwb_memtoreg_q, memwb_memtoreg_d;
  logic              memwb_regwrite_q, memwb_regwrite_d;
  logic [REG_AW-1:0] memwb_rd_q, memwb_rd_d;

  logic ex_match_s;
  logic hz_s;
  logic pcsrc_s;
  logic stall_s;
  logic bubble_s;

  // Hazard detection and branch resolution for the ID/EX boundary.
  always_comb begin
    ex_match_s = (idex_rd_q != {REG_AW{1'b0}}) &&
                 ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2));
`ifdef RV_CTRL_FORWARD_EN
    hz_s = idex_q.memread && ex_match_s;
`else
    // Without forwarding every pending write in EX or MEM must retire first.
    hz_s = ((idex_q.memread || idex_q.regwrite) && ex_match_s) ||
           (exmem_regwrite_q && (exmem_rd_q != {REG_AW{1'b0}}) &&
            ((exmem_rd_q == id_rs1) || (exmem_rd_q == id_rs2)));
`endif
    pcsrc_s  = idex_q.branch && ex_zero;
    // A taken branch squashes the stalled instruction anyway, so it wins.
    stall_s  = hz_s && !pcsrc_s;
    bubble_s = hz_s || pcsrc_s;
  end

  // Next-state for all three pipeline registers.
  always_comb begin
    idex_d     = '0;
    idex_rs1_d = '0;
    idex_rs2_d = '0;
    idex_rd_d  = '0;
    if (bubble_s) begin
      idex_d     = '0;
      idex_rs1_d = '0;
      idex_rs2_d = '0;
      idex_rd_d  = '0;
    end else begin
      idex_d.branch   = id_branch;
      idex_d.memread  = id_memread;
      // Only a definite 1 with a register write enables memtoreg; X/Z drops to 0.
      idex_d.memtoreg = id_regwrite && (id_memtoreg === 1'b1);
      idex_d.memwrite = id_memwrite;
      idex_d.alusrc   = id_alusrc;
      idex_d.regwrite = id_regwrite;
      idex_d.aluop    = id_aluop;
      idex_rs1_d      = id_rs1;
      idex_rs2_d      = id_rs2;
      idex_rd_d       = id_rd;
    end
    exmem_memread_d  = idex_q.memread;
    exmem_memwrite_d = idex_q.memwrite;
    exmem_memtoreg_d = idex_q.memtoreg;
    exmem_regwrite_d = idex_q.regwrite;
    exmem_rd_d       = idex_rd_q;
    memwb_memtoreg_d = exmem_memtoreg_q;
    memwb_regwrite_d = exmem_regwrite_q;
    memwb_rd_d       = exmem_rd_q;
  end

  // Pipeline register state; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q           <= '0;
      idex_rs1_q       <= '0;
      idex_rs2_q       <= '0;
      idex_rd_q        <= '0;
      exmem_memread_q  <= 1'b0;
      exmem_memwrite_q <= 1'b0;
      exmem_memtoreg_q <= 1'b0;
      exmem_regwrite_q <= 1'b0;
      exmem_rd_q       <= '0;
      memwb_memtoreg_q <= 1'b0;
      memwb_regwrite_q <= 1'b0;
      memwb_rd_q       <= '0;
    end else begin
      idex_q           <= idex_d;
      idex_rs1_q       <= idex_rs1_d;
      idex_rs2_q       <= idex_rs2_d;
      idex_rd_q        <= idex_rd_d;
      exmem_memread_q  <= exmem_memread_d;
      exmem_memwrite_q <= exmem_memwrite_d;
      exmem_memtoreg_q <= exmem_memtoreg_d;
      exmem_regwrite_q <= exmem_regwrite_d;
      exmem_rd_q       <= exmem_rd_d;
      memwb_memtoreg_q <= memwb_memtoreg_d;
      memwb_regwrite_q <= memwb_regwrite_d;
      memwb_rd_q       <= memwb_rd_d;
    end
  end

`ifdef RV_CTRL_FORWARD_EN
  rv_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs           (idex_rs1_q),
    .mem_regwrite (exmem_regwrite_q),
    .mem_rd       (exmem_rd_q),
    .wb_regwrite  (memwb_regwrite_q),
    .wb_rd        (memwb_rd_q),
    .fwd_sel      (fwd_a)
  );

  rv_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs           (idex_rs2_q),
    .mem_regwrite (exmem_regwrite_q),
    .mem_rd       (exmem_rd_q),
    .wb_regwrite  (memwb_regwrite_q),
    .wb_rd        (memwb_rd_q),
    .fwd_sel      (fwd_b)
  );
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign ex_branch    = idex_q.branch;
  assign ex_memread   = idex_q.memread;
  assign ex_memtoreg  = idex_q.memtoreg;
  assign ex_memwrite  = idex_q.memwrite;
  assign ex_alusrc    = idex_q.alusrc;
  assign ex_regwrite  = idex_q.regwrite;
  assign ex_aluop     = idex_q.aluop;
  assign ex_rs1       = idex_rs1_q;
  assign ex_rs2       = idex_rs2_q;
  assign ex_rd        = idex_rd_q;
  assign mem_memread  = exmem_memread_q;
  assign mem_memwrite = exmem_memwrite_q;
  assign mem_memtoreg = exmem_memtoreg_q;
  assign mem_regwrite = exmem_regwrite_q;
  assign mem_rd       = exmem_rd_q;
  assign wb_memtoreg  = memwb_memtoreg_q;
  assign wb_regwrite  = memwb_regwrite_q;
  assign wb_rd        = memwb_rd_q;
  assign pc_write     = !stall_s;
  assign ifid_write   = !stall_s;
  assign ifid_flush   = pcsrc_s;
  assign pcsrc        = pcsrc_s;

endmodule

// File: tb/tb_rv_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_rv_ctrl_pipe -- directed bench for rv_ctrl_pipe. A list of in-flight
// instructions (EX, MEM, WB) is kept as whole records and every output is
// derived from it each cycle; literal expectations along the way pin it.
// ---------------------------------------------------------------------------
module tb_rv_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0] id_aluop;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_zero;
  logic       ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
  logic [4:0] mem_rd;
  logic       wb_memtoreg, wb_regwrite;
  logic [4:0] wb_rd;
  logic       pc_write, ifid_write, ifid_flush, pcsrc;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  rv_ctrl_pipe #(.REG_AW(5), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_zero(ex_zero),
    .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
    .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_aluop(ex_aluop), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .pcsrc(pcsrc), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       br, mr, m2r, mw, as, rw;
    bit [1:0] op;
    bit [4:0] rs1, rs2, rd;
  } ins_t;

  ins_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB

  function automatic bit writes(input ins_t i, input bit [4:0] r);
    return i.rw && (i.rd != 5'd0) && (i.rd == r);
  endfunction

  function automatic bit m_pcsrc();
    return pipe[0].br && (ex_zero == 1'b1);
  endfunction

  function automatic bit m_hz();
    bit load_use;
    load_use = pipe[0].mr && (pipe[0].rd != 5'd0) &&
               ((pipe[0].rd == id_rs1) || (pipe[0].rd == id_rs2));
`ifdef RV_CTRL_FORWARD_EN
    return load_use;
`else
    return load_use || writes(pipe[0], id_rs1) || writes(pipe[0], id_rs2) ||
           writes(pipe[1], id_rs1) || writes(pipe[1], id_rs2);
`endif
  endfunction

  function automatic bit [1:0] m_fwd(input bit [4:0] r);
`ifdef RV_CTRL_FORWARD_EN
    if (writes(pipe[1], r)) return 2'd2;
    if (writes(pipe[2], r)) return 2'd1;
`endif
    return 2'd0;
  endfunction

  function automatic ins_t m_capture();
    ins_t n;
    n = '0;
    if (m_pcsrc() || m_hz()) return n;
    n.br  = id_branch;   n.mr = id_memread; n.mw = id_memwrite;
    n.as  = id_alusrc;   n.rw = id_regwrite; n.op = id_aluop;
    n.rs1 = id_rs1;      n.rs2 = id_rs2;     n.rd = id_rd;
    if (id_regwrite == 1'b1 && id_memtoreg == 1'b1) n.m2r = 1'b1;
    else n.m2r = 1'b0;
    return n;
  endfunction

  // Model advance on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= m_capture();
    end
  end

  // Full-output comparison every cycle, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ex_branch",   ex_branch,   pipe[0].br);
      check("m_ex_memread",  ex_memread,  pipe[0].mr);
      check("m_ex_memtoreg", ex_memtoreg, pipe[0].m2r);
      check("m_ex_memwrite", ex_memwrite, pipe[0].mw);
      check("m_ex_alusrc",   ex_alusrc,   pipe[0].as);
      check("m_ex_regwrite", ex_regwrite, pipe[0].rw);
      check("m_ex_aluop",    ex_aluop,    pipe[0].op);
      check("m_ex_rs1",      ex_rs1,      pipe[0].rs1);
      check("m_ex_rs2",      ex_rs2,      pipe[0].rs2);
      check("m_ex_rd",       ex_rd,       pipe[0].rd);
      check("m_mem_memread", mem_memread, pipe[1].mr);
      check("m_mem_memwrite",mem_memwrite,pipe[1].mw);
      check("m_mem_memtoreg",mem_memtoreg,pipe[1].m2r);
      check("m_mem_regwrite",mem_regwrite,pipe[1].rw);
      check("m_mem_rd",      mem_rd,      pipe[1].rd);
      check("m_wb_memtoreg", wb_memtoreg, pipe[2].m2r);
      check("m_wb_regwrite", wb_regwrite, pipe[2].rw);
      check("m_wb_rd",       wb_rd,       pipe[2].rd);
      check("m_pcsrc",       pcsrc,       m_pcsrc());
      check("m_ifid_flush",  ifid_flush,  m_pcsrc());
      check("m_pc_write",    pc_write,    !(m_hz() && !m_pcsrc()));
      check("m_ifid_write",  ifid_write,  !(m_hz() && !m_pcsrc()));
      check("m_fwd_a",       fwd_a,       m_fwd(pipe[0].rs1));
      check("m_fwd_b",       fwd_b,       m_fwd(pipe[0].rs2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_id(input bit br, input bit mr, input bit m2r, input bit mw,
                        input bit as, input bit rw, input bit [1:0] op,
                        input bit [4:0] r1, input bit [4:0] r2, input bit [4:0] rd);
    id_branch = br; id_memread = mr; id_memtoreg = m2r; id_memwrite = mw;
    id_alusrc = as; id_regwrite = rw; id_aluop = op;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    ex_zero = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
  endtask

  // Two producers of rdv, then a consumer of rdv on rs2.
  task automatic fwd_seq(input bit rw2, input bit [4:0] rdv,
                         input bit [1:0] exp_fwd, input bit exp_stall, input string nm);
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, rdv); cyc();
    set_id(0, 0, 0, 0, 0, rw2, 2'b10, 5'd0, 5'd0, rdv); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd7, 5'd8); settle();
`ifdef RV_CTRL_FORWARD_EN
    check({nm, "_pc_write"}, pc_write, 1'b1);
    cyc(); settle();
    check({nm, "_fwd_b"}, fwd_b, exp_fwd);
`else
    check({nm, "_pc_write"}, pc_write, !exp_stall);
    check({nm, "_fwd_b"}, fwd_b, 2'd0);
`endif
    drain();
  endtask

  initial begin
    reset = 1'b1; ex_zero = 1'b0; nop();
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    check("rst_ex_regwrite", ex_regwrite, 1'b0);
    check("rst_wb_rd",       wb_rd,       5'd0);
    check("rst_pc_write",    pc_write,    1'b1);
    check("rst_ifid_flush",  ifid_flush,  1'b0);
    check("rst_fwd_a",       fwd_a,       2'd0);

    // load-use: lw x5 then add rs1=5
    set_id(0, 1, 1, 0, 1, 1, 2'b00, 5'd1, 5'd0, 5'd5); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd5, 5'd6, 5'd7); settle();
    check("lu_pc_write",   pc_write,   1'b0);
    check("lu_ifid_write", ifid_write, 1'b0);
    cyc(); settle();
    check("lu_bubble_memread", ex_memread, 1'b0);
    check("lu_bubble_rd",      ex_rd,      5'd0);
    check("lu_mem_memread",    mem_memread,1'b1);
`ifdef RV_CTRL_FORWARD_EN
    check("lu_release", pc_write, 1'b1);
    cyc(); settle();
    check("lu_add_rd", ex_rd, 5'd7);
    check("lu_fwd_a",  fwd_a, 2'd1);
`else
    check("lu_mem_stall", pc_write, 1'b0);
    cyc(); settle();
    check("lu_release", pc_write, 1'b1);
    cyc(); settle();
    check("lu_add_rd", ex_rd, 5'd7);
    check("lu_fwd_a",  fwd_a, 2'd0);
`endif
    drain();

    // forwarding priority
    fwd_seq(1'b1, 5'd7, 2'd2, 1'b1, "fwd_mem");
    fwd_seq(1'b0, 5'd7, 2'd1, 1'b1, "fwd_wb");
    fwd_seq(1'b1, 5'd0, 2'd0, 1'b0, "fwd_x0");

    // taken branch
    set_id(1, 0, 0, 0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd9, 5'd0, 5'd10); ex_zero = 1'b1; settle();
    check("br_pcsrc",      pcsrc,      1'b1);
    check("br_flush",      ifid_flush, 1'b1);
    check("br_pc_write",   pc_write,   1'b1);
    check("br_ifid_write", ifid_write, 1'b1);
    cyc(); ex_zero = 1'b0; settle();
    check("br_bubble_rw", ex_regwrite, 1'b0);
    check("br_bubble_br", ex_branch,   1'b0);
    cyc();
    set_id(1, 0, 0, 0, 0, 0, 2'b01, 5'd1, 5'd2, 5'd0); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd9, 5'd0, 5'd10); settle();
    check("nt_pcsrc", pcsrc,      1'b0);
    check("nt_flush", ifid_flush, 1'b0);
    cyc(); settle();
    check("nt_ex_rd", ex_rd, 5'd10);
    drain();

    // branch and load-use hazard together
    set_id(1, 1, 0, 0, 0, 1, 2'b01, 5'd0, 5'd0, 5'd4); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd4, 5'd0, 5'd11); ex_zero = 1'b1; settle();
    check("bh_pc_write",   pc_write,   1'b1);
    check("bh_ifid_write", ifid_write, 1'b1);
    check("bh_flush",      ifid_flush, 1'b1);
    cyc(); ex_zero = 1'b0; nop(); settle();
    check("bh_bubble_rw", ex_regwrite, 1'b0);
    check("bh_mem_rd",    mem_rd,      5'd4);
    check("bh_pc_write2", pc_write,    1'b1);
    drain();

    // reset mid-stream
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd1); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd2); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd3); cyc();
    nop(); settle();
    check("rs_pre_wb_rd", wb_rd, 5'd1);
    check("rs_pre_ex_rd", ex_rd, 5'd3);
    reset = 1'b1; cyc(); reset = 1'b0; settle();
    check("rs_ex_rw",  ex_regwrite,  1'b0);
    check("rs_mem_rw", mem_regwrite, 1'b0);
    check("rs_wb_rw",  wb_regwrite,  1'b0);
    check("rs_mem_rd", mem_rd,       5'd0);
    check("rs_pc_write", pc_write,   1'b1);

    // store capture with unknown memtoreg
    set_id(0, 0, 0, 1, 1, 0, 2'b00, 5'd2, 5'd3, 5'd0); id_memtoreg = 1'bx; cyc(); settle();
    check("st_memtoreg", ex_memtoreg, 1'b0);
    check("st_memwrite", ex_memwrite, 1'b1);
    set_id(0, 0, 1, 1, 1, 0, 2'b00, 5'd2, 5'd3, 5'd0); cyc(); settle();
    check("st_m2r_norw", ex_memtoreg, 1'b0);
    set_id(0, 1, 1, 0, 1, 1, 2'b00, 5'd2, 5'd0, 5'd12); cyc(); settle();
    check("ld_memtoreg", ex_memtoreg, 1'b1);
    drain();

    // ALU RAW against EX: add x3 then sub rs1=3
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd0, 5'd0, 5'd3); cyc();
    set_id(0, 0, 0, 0, 0, 1, 2'b10, 5'd3, 5'd0, 5'd4); settle();
`ifdef RV_CTRL_FORWARD_EN
    check("raw_pc_write", pc_write, 1'b1);
`else
    check("raw_pc_write",   pc_write,   1'b0);
    check("raw_ifid_write", ifid_write, 1'b0);
`endif
    drain();

    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_pipe.md
Name: rv_ctrl_pipe

Overview:
- Consumer end of the main-decoder control bundle.
- Carries branch/memread/memtoreg/ALUOp/memwrite/ALUsrc/regwrite plus register indices from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles; squashes wrong-path instructions on a taken branch; generates forwarding selects.
- Sits beside the datapath pipeline registers in the 5-stage core.

Parameters:
- REG_AW, 5, register-index width.
- ALUOP_W, 2, ALUOp width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  decoder outputs for the instruction in ID.
- id_aluop  in  ALUOP_W  decoder ALUOp.
- id_rs1, id_rs2, id_rd  in  REG_AW each  ID register fields.
- ex_zero  in  1  ALU zero flag for the instruction in EX.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  ID/EX control.
- ex_aluop  out  ALUOP_W  ID/EX ALUOp.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each  ID/EX indices.
- mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite  out  1 each  EX/MEM control.
- mem_rd  out  REG_AW  EX/MEM destination.
- wb_memtoreg, wb_regwrite  out  1 each  MEM/WB control.
- wb_rd  out  REG_AW  MEM/WB destination.
- pc_write, ifid_write  out  1 each  0 = hold PC / IF-ID register.
- ifid_flush  out  1  1 = clear IF/ID to NOP next edge.
- pcsrc  out  1  1 = select branch target.
- fwd_a, fwd_b  out  2 each  ALU operand select.

Behaviour:
- Reset (sync, active-high):
  - All registered control outputs and all rd/rs outputs go to 0.
  - Combinational outputs follow from the zeroed state: pc_write=1, ifid_write=1, ifid_flush=0, pcsrc=0, fwd_a=fwd_b=00.
  - Reset mid-operation discards all in-flight control; there is no drain.
- Capture sanitation:
  - Any X/Z on id_memtoreg is captured as 0.
  - If id_regwrite=0, memtoreg is captured as 0.
- pcsrc = ex_branch & ex_zero. Combinational; branch resolves in EX.
- Load-use hazard:
  - hz = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
  - On hz: pc_write=0 and ifid_write=0, and ID/EX loads a bubble (all control 0, indices 0).
  - EX/MEM and MEM/WB always advance.
- Taken branch (pcsrc=1):
  - ID/EX loads a bubble and ifid_flush=1.
  - pc_write=1 and ifid_write=1.
  - Branch has priority over hz; the stall is suppressed that cycle.
- Normal cycle: ID/EX <= id_* bundle; EX/MEM <= EX subset; MEM/WB <= MEM subset. Each stage has 1-cycle latency.
- Forwarding (for ex_rs1; ex_rs2 is identical):
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1.
  - Else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1.
  - Else 00.
  - EX/MEM has priority over MEM/WB.
- Register x0 never creates a hazard or a forward.
- Register file is write-before-read, so a WB-stage match never stalls.

Optional Feature:
- Macro: RV_CTRL_FORWARD_EN.
- Defined: forwarding as above, and only load-use stalls are generated.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - hz widens to any RAW against EX (ex_regwrite, ex_rd!=0) or MEM (mem_regwrite, mem_rd!=0) on id_rs1 or id_rs2.
  - Stall mechanics are unchanged.
  - Branch still has priority.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (R=0110011, LOAD=0000011, STORE=0100011, BRANCH=1100011, OPIMM=0010011);
  - ALUOp encodings 00/01/10;
  - forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10;
  - packed struct ctrl_bundle_t.
- One natural sub-module: rv_fwd_unit, the combinational forwarding compare, instantiated once per operand.

Test Plan:
- Load-use: lw x5 in EX (ex_memread=1, ex_rd=5), ID add rs1=5 -> pc_write=0, ifid_write=0; next cycle ex_* all 0; following cycle the add enters EX with fwd_a=01.
- Forward priority: mem_rd=wb_rd=7, both regwrite=1, ex_rs2=7 -> fwd_b=10; drop mem_regwrite -> fwd_b=01; set rd=0 -> fwd_b=00.
- Taken branch: ex_branch=1, ex_zero=1 -> pcsrc=1, ifid_flush=1; next cycle ex_* all 0; same stimulus with ex_zero=0 -> pcsrc=0, no flush.
- Branch plus hazard in the same cycle: pcsrc=1 and hz conditions met -> pc_write=1, ifid_flush=1, bubble inserted once.
- Reset mid-stream: three back-to-back R-type ops in flight, assert reset one cycle -> all ex_/mem_/wb_ outputs 0, pc_write=1 on the following cycle.
- Store capture with id_memtoreg=X and id_regwrite=0 -> ex_memtoreg=0 and ex_memwrite=1; with RV_CTRL_FORWARD_EN undefined, add x3 in EX and ID sub rs1=3 -> stall asserted.
